// File: rtl/sn74_nibble_demux.sv
// Reassembles A-then-B nibble pairs from a time-multiplexed 4-bit bus into 8-bit words.
// The words leave on a valid/ready port; sequence, timeout and overflow faults are kept as sticky flags.
//
// state  | meaning
// IDLE   | no A nibble held; waiting for an A beat
// HAVE_A | A nibble held; waiting for the B beat while the timer runs
module sn74_nibble_demux #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       din,
    input  logic             sel,
    input  logic             str,
    output logic [7:0]       out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_seq,
    output logic             err_tmo,
    output logic             err_ovf,
    input  logic             err_clr,
    output logic [CNT_W-1:0] pair_cnt
);

    localparam logic IDLE   = 1'b0;
    localparam logic HAVE_A = 1'b1;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic             state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [7:0]       timer_q, timer_d;
    logic [7:0]       out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_seq_q, err_seq_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_ovf_q, err_ovf_d;
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;

    logic beat;
    logic slot_free;
    logic set_seq, set_tmo, set_ovf;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        timer_d     = timer_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        pair_cnt_d  = pair_cnt_q;
        set_seq     = 1'b0;
        set_tmo     = 1'b0;
        set_ovf     = 1'b0;

        beat      = ~str;
        slot_free = ~out_valid_q | out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == IDLE) begin
            if (beat) begin
                if (!sel) begin
                    a_d     = din;
                    timer_d = 8'd0;
                    state_d = HAVE_A;
                end else begin
                    set_seq = 1'b1;
                end
            end
        end else begin
            if (beat) begin
                if (!sel) begin
                    a_d     = din;
                    timer_d = 8'd0;
                end else begin
                    state_d = IDLE;
                    timer_d = 8'd0;
                    // A full slot that is not being accepted this cycle drops the new word.
                    if (slot_free) begin
                        out_d       = {a_q, din};
                        out_valid_d = 1'b1;
                        pair_cnt_d  = pair_cnt_q + 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
            end else if (timer_q == TMO_LAST) begin
                set_tmo = 1'b1;
                state_d = IDLE;
                timer_d = 8'd0;
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end

        // A new error in the same cycle as err_clr leaves the flag set.
        err_seq_d = (err_seq_q & ~err_clr) | set_seq;
        err_tmo_d = (err_tmo_q & ~err_clr) | set_tmo;
        err_ovf_d = (err_ovf_q & ~err_clr) | set_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= 4'd0;
            timer_q     <= 8'd0;
            out_q       <= 8'd0;
            out_valid_q <= 1'b0;
            err_seq_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            pair_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            timer_q     <= timer_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_seq_q   <= err_seq_d;
            err_tmo_q   <= err_tmo_d;
            err_ovf_q   <= err_ovf_d;
            pair_cnt_q  <= pair_cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err_seq   = err_seq_q;
    assign err_tmo   = err_tmo_q;
    assign err_ovf   = err_ovf_q;
    assign pair_cnt  = pair_cnt_q;

endmodule

// File: tb/tb_sn74_nibble_demux.sv
// Bench for sn74_nibble_demux: directed scenarios plus random traffic against a
// pair-level reference model (pending A, wait count, output slot, sticky flags).
module tb_sn74_nibble_demux;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       din;
    logic             sel;
    logic             str;
    logic [7:0]       out;
    logic             out_valid;
    logic             out_ready;
    logic             err_seq;
    logic             err_tmo;
    logic             err_ovf;
    logic             err_clr;
    logic [CNT_W-1:0] pair_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit               m_pend;
    logic [3:0]       m_a;
    int               m_wait;
    logic [7:0]       m_out;
    bit               m_valid;
    bit               m_seq, m_tmo, m_ovf;
    logic [CNT_W-1:0] m_cnt;

    sn74_nibble_demux #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .str(str),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .err_seq(err_seq), .err_tmo(err_tmo), .err_ovf(err_ovf),
        .err_clr(err_clr), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = 0; m_a = 4'd0; m_wait = 0;
        m_out = 8'd0; m_valid = 0;
        m_seq = 0; m_tmo = 0; m_ovf = 0;
        m_cnt = '0;
    endtask

    // One clock edge of the link protocol, written in terms of pairs and waiting time.
    task automatic model_edge(input bit s_str, input bit s_sel, input logic [3:0] s_din,
                              input bit s_rdy, input bit s_clr);
        bit beat = !s_str;
        bit free = !m_valid || s_rdy;
        bit sq = 0, tm = 0, ov = 0;
        if (m_valid && s_rdy) m_valid = 0;
        if (beat && s_sel) begin
            if (m_pend) begin
                m_pend = 0;
                if (free) begin
                    m_out   = {m_a, s_din};
                    m_valid = 1;
                    m_cnt   = m_cnt + 1'b1;
                end else begin
                    ov = 1;
                end
            end else begin
                sq = 1;
            end
        end else if (beat) begin
            m_a = s_din; m_pend = 1; m_wait = 0;
        end else if (m_pend) begin
            m_wait++;
            if (m_wait >= TIMEOUT) begin
                tm = 1; m_pend = 0;
            end
        end
        m_seq = (m_seq && !s_clr) || sq;
        m_tmo = (m_tmo && !s_clr) || tm;
        m_ovf = (m_ovf && !s_clr) || ov;
    endtask

    task automatic step(input logic [7:0] v);
        str = v[7]; sel = v[6]; din = v[5:2]; out_ready = v[1]; err_clr = v[0];
        @(posedge clk);
        model_edge(v[7], v[6], v[5:2], v[1], v[0]);
        #1;
    endtask

    function automatic logic [7:0] pk(input logic s, input logic sl, input logic [3:0] d,
                                      input logic r, input logic c);
        return {s, sl, d, r, c};
    endfunction

    task automatic apply_reset();
        str = 1'b1; sel = 1'b0; din = 4'd0; out_ready = 1'b1; err_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; str = 1'b1; sel = 1'b0; din = 4'd0; out_ready = 1'b0; err_clr = 1'b0;
        model_reset();
        #1;
        checks += 3;
        if (out !== 8'h00 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out got %h/%b exp 00/0", out, out_valid);
        end
        if ({err_seq, err_tmo, err_ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_err got %b exp 000", {err_seq, err_tmo, err_ovf});
        end
        if (pair_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d exp 0", pair_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_pair();
        logic [7:0] s[$];
        apply_reset();
        s = '{pk(0,0,4'ha,1,0), pk(0,1,4'hf,1,0), pk(1,0,4'h0,1,0)};
        foreach (s[i]) begin
            step(s[i]);
            checks += 4;
            if (out !== m_out) begin errors++; $display("FAIL basic_out[%0d] got %h exp %h", i, out, m_out); end
            if (out_valid !== m_valid) begin errors++; $display("FAIL basic_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            if ({err_seq, err_tmo, err_ovf} !== {m_seq, m_tmo, m_ovf}) begin
                errors++; $display("FAIL basic_err[%0d] got %b exp %b", i, {err_seq, err_tmo, err_ovf}, {m_seq, m_tmo, m_ovf});
            end
            if (pair_cnt !== m_cnt) begin errors++; $display("FAIL basic_cnt[%0d] got %0d exp %0d", i, pair_cnt, m_cnt); end
            if (i == 1) begin
                checks++;
                if (out !== 8'haf || out_valid !== 1'b1 || pair_cnt !== 2'd1) begin
                    errors++; $display("FAIL basic_word got %h/%b/%0d exp af/1/1", out, out_valid, pair_cnt);
                end
            end
        end
    endtask

    task automatic test_strobe_gating();
        logic [7:0] s[$];
        apply_reset();
        s = '{pk(1,0,4'h5,1,0), pk(1,1,4'h5,1,0), pk(1,0,4'h5,1,0), pk(1,1,4'h5,1,0),
              pk(0,0,4'h3,1,0), pk(0,1,4'hc,1,0)};
        foreach (s[i]) begin
            step(s[i]);
            checks += 4;
            if (out !== m_out) begin errors++; $display("FAIL strobe_out[%0d] got %h exp %h", i, out, m_out); end
            if (out_valid !== m_valid) begin errors++; $display("FAIL strobe_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            if ({err_seq, err_tmo, err_ovf} !== {m_seq, m_tmo, m_ovf}) begin
                errors++; $display("FAIL strobe_err[%0d] got %b exp %b", i, {err_seq, err_tmo, err_ovf}, {m_seq, m_tmo, m_ovf});
            end
            if (pair_cnt !== m_cnt) begin errors++; $display("FAIL strobe_cnt[%0d] got %0d exp %0d", i, pair_cnt, m_cnt); end
        end
        checks++;
        if (out !== 8'h3c) begin errors++; $display("FAIL strobe_word got %h exp 3c", out); end
    endtask

    task automatic test_seq_errors();
        logic [7:0] s[$];
        apply_reset();
        s = '{pk(0,1,4'h9,1,0), pk(0,0,4'h1,1,0), pk(0,0,4'h2,1,0), pk(0,1,4'h4,1,0),
              pk(1,0,4'h0,1,1), pk(1,0,4'h0,1,0)};
        foreach (s[i]) begin
            step(s[i]);
            checks += 4;
            if (out !== m_out) begin errors++; $display("FAIL seq_out[%0d] got %h exp %h", i, out, m_out); end
            if (out_valid !== m_valid) begin errors++; $display("FAIL seq_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            if ({err_seq, err_tmo, err_ovf} !== {m_seq, m_tmo, m_ovf}) begin
                errors++; $display("FAIL seq_err[%0d] got %b exp %b", i, {err_seq, err_tmo, err_ovf}, {m_seq, m_tmo, m_ovf});
            end
            if (pair_cnt !== m_cnt) begin errors++; $display("FAIL seq_cnt[%0d] got %0d exp %0d", i, pair_cnt, m_cnt); end
            if (i == 3) begin
                checks++;
                if (out !== 8'h24 || err_seq !== 1'b1) begin
                    errors++; $display("FAIL seq_word got %h/%b exp 24/1", out, err_seq);
                end
            end
        end
        checks++;
        if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_clear got %b exp 0", err_seq); end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        apply_reset();
        s.push_back(pk(0,0,4'h7,1,0));
        for (int k = 0; k < TIMEOUT; k++) s.push_back(pk(1,0,4'h0,1,0));
        s.push_back(pk(0,1,4'h1,1,0));
        s.push_back(pk(1,0,4'h0,1,1));
        s.push_back(pk(0,0,4'h7,1,0));
        for (int k = 0; k < TIMEOUT - 1; k++) s.push_back(pk(1,0,4'h0,1,0));
        s.push_back(pk(0,1,4'hb,1,0));
        foreach (s[i]) begin
            step(s[i]);
            checks += 4;
            if (out !== m_out) begin errors++; $display("FAIL tmo_out[%0d] got %h exp %h", i, out, m_out); end
            if (out_valid !== m_valid) begin errors++; $display("FAIL tmo_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            if ({err_seq, err_tmo, err_ovf} !== {m_seq, m_tmo, m_ovf}) begin
                errors++; $display("FAIL tmo_err[%0d] got %b exp %b", i, {err_seq, err_tmo, err_ovf}, {m_seq, m_tmo, m_ovf});
            end
            if (pair_cnt !== m_cnt) begin errors++; $display("FAIL tmo_cnt[%0d] got %0d exp %0d", i, pair_cnt, m_cnt); end
            if (i == TIMEOUT) begin
                checks++;
                if (err_tmo !== 1'b1) begin errors++; $display("FAIL tmo_expire got %b exp 1", err_tmo); end
            end
            if (i == TIMEOUT + 1) begin
                checks++;
                if (err_seq !== 1'b1 || out_valid !== 1'b0) begin
                    errors++; $display("FAIL tmo_late_b got %b/%b exp 1/0", err_seq, out_valid);
                end
            end
        end
        checks++;
        if (out !== 8'h7b || out_valid !== 1'b1 || err_tmo !== 1'b0) begin
            errors++; $display("FAIL tmo_edge_b got %h/%b/%b exp 7b/1/0", out, out_valid, err_tmo);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s[$];
        apply_reset();
        s = '{pk(0,0,4'h1,0,0), pk(0,1,4'h2,0,0), pk(0,0,4'h3,0,0), pk(0,1,4'h4,0,0),
              pk(1,0,4'h0,0,0), pk(1,0,4'h0,1,0), pk(1,0,4'h0,1,0)};
        foreach (s[i]) begin
            step(s[i]);
            checks += 4;
            if (out !== m_out) begin errors++; $display("FAIL bp_out[%0d] got %h exp %h", i, out, m_out); end
            if (out_valid !== m_valid) begin errors++; $display("FAIL bp_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            if ({err_seq, err_tmo, err_ovf} !== {m_seq, m_tmo, m_ovf}) begin
                errors++; $display("FAIL bp_err[%0d] got %b exp %b", i, {err_seq, err_tmo, err_ovf}, {m_seq, m_tmo, m_ovf});
            end
            if (pair_cnt !== m_cnt) begin errors++; $display("FAIL bp_cnt[%0d] got %0d exp %0d", i, pair_cnt, m_cnt); end
            if (i == 4) begin
                checks++;
                if (out !== 8'h12 || err_ovf !== 1'b1 || pair_cnt !== 2'd1 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_hold got %h/%b/%0d/%b exp 12/1/1/1", out, err_ovf, pair_cnt, out_valid);
                end
            end
            if (i == 5) begin
                checks++;
                if (out_valid !== 1'b0 || out !== 8'h12) begin
                    errors++; $display("FAIL bp_accept got %b/%h exp 0/12", out_valid, out);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        logic [CNT_W-1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int np = 0;
        apply_reset();
        for (int p = 0; p < 5; p++) begin
            s.push_back(pk(0,0,4'(p + 1),1,0));
            s.push_back(pk(0,1,4'(p + 8),1,0));
        end
        foreach (s[i]) begin
            step(s[i]);
            checks += 4;
            if (out !== m_out) begin errors++; $display("FAIL b2b_out[%0d] got %h exp %h", i, out, m_out); end
            if (out_valid !== m_valid) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            if ({err_seq, err_tmo, err_ovf} !== {m_seq, m_tmo, m_ovf}) begin
                errors++; $display("FAIL b2b_err[%0d] got %b exp %b", i, {err_seq, err_tmo, err_ovf}, {m_seq, m_tmo, m_ovf});
            end
            if (pair_cnt !== m_cnt) begin errors++; $display("FAIL b2b_cnt[%0d] got %0d exp %0d", i, pair_cnt, m_cnt); end
            if (s[i][6]) begin
                checks++;
                if (pair_cnt !== exp_cnt[np] || err_ovf !== 1'b0) begin
                    errors++; $display("FAIL b2b_wrap[%0d] got %0d/%b exp %0d/0", np, pair_cnt, err_ovf, exp_cnt[np]);
                end
                np++;
            end
        end
        step(pk(0,0,4'h6,1,0));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || pair_cnt !== '0 || {err_seq, err_tmo, err_ovf} !== 3'b000) begin
            errors++; $display("FAIL midpair_reset got %h/%b/%0d/%b exp 00/0/0/000",
                                out, out_valid, pair_cnt, {err_seq, err_tmo, err_ovf});
        end
        str = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(pk(0,1,4'h3,1,0));
        checks++;
        if (out_valid !== 1'b0 || err_seq !== 1'b1) begin
            errors++; $display("FAIL midpair_lost got %b/%b exp 0/1", out_valid, err_seq);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            logic s_str = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
            step(pk(s_str, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0)));
            checks += 4;
            if (out !== m_out) begin errors++; $display("FAIL rand_out[%0d] got %h exp %h", i, out, m_out); end
            if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            if ({err_seq, err_tmo, err_ovf} !== {m_seq, m_tmo, m_ovf}) begin
                errors++; $display("FAIL rand_err[%0d] got %b exp %b", i, {err_seq, err_tmo, err_ovf}, {m_seq, m_tmo, m_ovf});
            end
            if (pair_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt[%0d] got %0d exp %0d", i, pair_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_strobe_gating();
        test_seq_errors();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
